// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit word is split into
// STAGES slices of SLICE = WIDTH/STAGES bits. Each pipeline stage adds one
// slice with 4-bit lookahead groups and a second lookahead level across the
// groups of the slice, then registers its slice sum, the slice carry out and
// the running whole-word group propagate/generate. Operand slices that are
// still waiting for their stage ride along in skew registers, and finished
// low sum slices ride along in deskew registers, so the full sum leaves the
// last stage in a single cycle.
//
// An input capture rank registers the effective operands on acceptance, so an
// operation accepted at edge t is presented after edge t+STAGES. The pipeline
// uses a global stall: every rank advances together when the output slot is
// empty or being consumed.
//
// WIDTH must be a multiple of 4*STAGES.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (not a borrow when sub=1)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   grp_p      whole-word group propagate
//   grp_g      whole-word group generate
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / 4;

    // Packed slice result: {ovf, slice_g, slice_p, carry_out, sum[SLICE-1:0]}
    localparam int RES_W = SLICE + 4;

    // Carries into bits 1..3 of a 4-bit lookahead group, flattened.
    function automatic logic [2:0] cla4_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       ci
    );
        logic c1;
        logic c2;
        logic c3;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {c3, c2, c1};
    endfunction

    // One slice: group P/G per 4 bits, then a sum-of-products lookahead over
    // the groups so each group carry-in depends only on group P/G and ci.
    function automatic logic [RES_W-1:0] cla_slice(
        input logic [SLICE-1:0] sa,
        input logic [SLICE-1:0] sb,
        input logic             ci
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] s;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic [NGRP:0]    gc;
        logic [SLICE:0]   c;
        logic [2:0]       c3;
        logic             acc;
        logic             prop;
        logic             sg;
        p = sa ^ sb;
        g = sa & sb;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = ci;
        for (int j = 1; j <= NGRP; j++) begin
            acc  = 1'b0;
            prop = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc  = acc | (gg[i] & prop);
                prop = prop & gp[i];
            end
            gc[j] = acc | (ci & prop);
        end
        for (int j = 0; j < NGRP; j++) begin
            c3         = cla4_carry(g[4*j +: 4], p[4*j +: 4], gc[j]);
            c[4*j]     = gc[j];
            c[4*j + 1] = c3[0];
            c[4*j + 2] = c3[1];
            c[4*j + 3] = c3[2];
        end
        c[SLICE] = gc[NGRP];
        s = p ^ c[SLICE-1:0];
        // Slice generate is the slice carry out with a zero carry in.
        sg = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            sg = gg[j] | (gp[j] & sg);
        end
        return {c[SLICE-1] ^ c[SLICE], sg, &gp, c[SLICE], s};
    endfunction

    // Rank 0 is the input capture; rank k+1 holds the result of stage k.
    logic             vld_q [0:STAGES];
    logic             vld_d [0:STAGES];
    logic [WIDTH-1:0] a_q   [0:STAGES-1];
    logic [WIDTH-1:0] a_d   [0:STAGES-1];
    logic [WIDTH-1:0] b_q   [0:STAGES-1];
    logic [WIDTH-1:0] b_d   [0:STAGES-1];
    logic [WIDTH-1:0] sum_q [0:STAGES];
    logic [WIDTH-1:0] sum_d [0:STAGES];
    logic             c_q   [0:STAGES];
    logic             c_d   [0:STAGES];
    logic             p_q   [0:STAGES];
    logic             p_d   [0:STAGES];
    logic             g_q   [0:STAGES];
    logic             g_d   [0:STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic [RES_W-1:0] res_s [0:STAGES-1];
    logic             adv_s;

    // Global stall: everything moves when the output slot is free or consumed.
    always_comb begin
        adv_s = !vld_q[STAGES] || out_ready;
    end

    // Per-stage slice addition on the rank feeding that stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_s[k] = cla_slice(a_q[k][k*SLICE +: SLICE], b_q[k][k*SLICE +: SLICE], c_q[k]);
        end
    end

    // Next-state for all ranks; data only loads when a valid op moves in, so
    // bubbles never overwrite held results.
    always_comb begin
        logic             take;
        logic             ld;
        logic [WIDTH-1:0] sum_nx;

        take     = adv_s & in_valid;
        vld_d[0] = adv_s ? in_valid : vld_q[0];
        a_d[0]   = take ? a : a_q[0];
        b_d[0]   = take ? (sub ? ~b : b) : b_q[0];
        c_d[0]   = take ? (sub | cin) : c_q[0];
        p_d[0]   = take ? 1'b1 : p_q[0];
        g_d[0]   = take ? 1'b0 : g_q[0];
        sum_d[0] = take ? {WIDTH{1'b0}} : sum_q[0];

        for (int k = 0; k < STAGES; k++) begin
            ld         = adv_s & vld_q[k];
            sum_nx     = sum_q[k];
            sum_nx[k*SLICE +: SLICE] = res_s[k][SLICE-1:0];
            vld_d[k+1] = adv_s ? vld_q[k] : vld_q[k+1];
            sum_d[k+1] = ld ? sum_nx : sum_q[k+1];
            c_d[k+1]   = ld ? res_s[k][SLICE] : c_q[k+1];
            p_d[k+1]   = ld ? (p_q[k] & res_s[k][SLICE+1]) : p_q[k+1];
            g_d[k+1]   = ld ? (res_s[k][SLICE+2] | (res_s[k][SLICE+1] & g_q[k])) : g_q[k+1];
        end

        // Skew registers: unconsumed operand slices follow their operation.
        for (int k = 0; k < STAGES - 1; k++) begin
            a_d[k+1] = (adv_s & vld_q[k]) ? a_q[k] : a_q[k+1];
            b_d[k+1] = (adv_s & vld_q[k]) ? b_q[k] : b_q[k+1];
        end

        ovf_d = (adv_s & vld_q[STAGES-1]) ? res_s[STAGES-1][SLICE+3] : ovf_q;
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= STAGES; r++) begin
                vld_q[r] <= 1'b0;
                sum_q[r] <= {WIDTH{1'b0}};
                c_q[r]   <= 1'b0;
                p_q[r]   <= 1'b0;
                g_q[r]   <= 1'b0;
            end
            for (int r = 0; r < STAGES; r++) begin
                a_q[r] <= {WIDTH{1'b0}};
                b_q[r] <= {WIDTH{1'b0}};
            end
            ovf_q <= 1'b0;
        end else begin
            for (int r = 0; r <= STAGES; r++) begin
                vld_q[r] <= vld_d[r];
                sum_q[r] <= sum_d[r];
                c_q[r]   <= c_d[r];
                p_q[r]   <= p_d[r];
                g_q[r]   <= g_d[r];
            end
            for (int r = 0; r < STAGES; r++) begin
                a_q[r] <= a_d[r];
                b_q[r] <= b_d[r];
            end
            ovf_q <= ovf_d;
        end
    end

    // Outputs come straight from the last rank.
    always_comb begin
        in_ready  = adv_s;
        out_valid = vld_q[STAGES];
        sum       = sum_q[STAGES];
        cout      = c_q[STAGES];
        ovf       = ovf_q;
        grp_p     = p_q[STAGES];
        grp_g     = g_q[STAGES];
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: three instances (32/4, 16/1, 64/8)
// share operand buses; each has its own valid and expected-result queue.
module tb_pipelined_cla_adder;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        gp;
        logic        gg;
        int          t;
        int          st;
    } exp_t;

    int W  [3] = '{32, 16, 64};
    int ST [3] = '{4, 1, 8};

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  orr;
    logic [63:0] a_s;
    logic [63:0] b_s;
    logic        cin_s;
    logic        sub_s;

    wire        ir0, ir1, ir2, ov0, ov1, ov2;
    wire [31:0] sum0;
    wire [15:0] sum1;
    wire [63:0] sum2;
    wire        co0, co1, co2, of0, of1, of2, gp0, gp1, gp2, gg0, gg1, gg2;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int stalls [3] = '{0, 0, 0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(ov0), .out_ready(orr[0]), .sum(sum0), .cout(co0),
        .ovf(of0), .grp_p(gp0), .grp_g(gg0));

    pipelined_cla_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(ov1), .out_ready(orr[1]), .sum(sum1), .cout(co1),
        .ovf(of1), .grp_p(gp1), .grp_g(gg1));

    pipelined_cla_adder #(.WIDTH(64), .STAGES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
        .out_valid(ov2), .out_ready(orr[2]), .sum(sum2), .cout(co2),
        .ovf(of2), .grp_p(gp2), .grp_g(gg2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] get_sum(input int i);
        case (i)
            0:       return {32'd0, sum0};
            1:       return {48'd0, sum1};
            default: return sum2;
        endcase
    endfunction

    // {in_ready, out_valid, cout, ovf, grp_p, grp_g}
    function automatic logic [5:0] get_fl(input int i);
        case (i)
            0:       return {ir0, ov0, co0, of0, gp0, gg0};
            1:       return {ir1, ov1, co1, of1, gp1, gg1};
            default: return {ir2, ov2, co2, of2, gp2, gg2};
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Reference: plain wide arithmetic on the effective operands.
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] ae;
        logic [63:0] be;
        logic [63:0] msb;
        logic [64:0] full;
        logic [64:0] gfull;
        m     = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        ae    = av & m;
        be    = (sb ? ~bv : bv) & m;
        full  = {1'b0, ae} + {1'b0, be} + (sb ? 65'd1 : {64'd0, ci});
        gfull = {1'b0, ae} + {1'b0, be};
        msb   = 64'd1 << (w - 1);
        e.s   = full[63:0] & m;
        e.co  = full[w];
        e.gg  = gfull[w];
        e.gp  = ((ae ^ be) == m);
        e.ov  = (((ae & msb) != 0) == ((be & msb) != 0)) && (((e.s & msb) != 0) != ((ae & msb) != 0));
        e.t   = 0;
        e.st  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exv);
        ncmp++;
        if (act !== exv) begin
            nfail++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, inst, act, exv);
        end
    endtask

    // Monitor: pop/compare consumed results, count stalls, record acceptances.
    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] fl;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            fl = get_fl(i);
            if (rst_n && fl[4] && orr[i]) begin
                if (qsize(i) == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_result inst%0d: got sum %h, expected no result", i, get_sum(i));
                end else begin
                    e = qpop(i);
                    chk("sum", i, get_sum(i), e.s);
                    chk("cout", i, {63'd0, fl[3]}, {63'd0, e.co});
                    chk("ovf", i, {63'd0, fl[2]}, {63'd0, e.ov});
                    chk("grp_p", i, {63'd0, fl[1]}, {63'd0, e.gp});
                    chk("grp_g", i, {63'd0, fl[0]}, {63'd0, e.gg});
                    chk("latency", i, 64'(cyc - e.t), 64'(ST[i] + 1 + stalls[i] - e.st));
                end
            end
            if (rst_n && fl[4] && !orr[i]) stalls[i]++;
            if (rst_n && iv[i] && fl[5]) begin
                e    = model(W[i], a_s, b_s, cin_s, sub_s);
                e.t  = cyc;
                e.st = stalls[i];
                qpush(i, e);
            end
        end
    end

    // Present one operation and hold it until accepted (bounded).
    task automatic send(input int inst, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb);
        logic [5:0] fl;
        bit         done;
        int         guard;
        a_s = av; b_s = bv; cin_s = ci; sub_s = sb;
        iv[inst] = 1'b1;
        done  = 1'b0;
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            fl   = get_fl(inst);
            done = fl[5];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done) begin
            ncmp++;
            nfail++;
            $display("FAIL accept_timeout inst%0d: got no acceptance, expected within 50 cycles", inst);
        end
    endtask

    // Drop valid and scramble the operand buses (must not be sampled).
    task automatic idle(input int inst);
        iv[inst] = 1'b0;
        a_s = {$urandom(), $urandom()};
        b_s = {$urandom(), $urandom()};
        cin_s = 1'($urandom_range(0, 1));
        sub_s = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic directed(input int i);
        logic [63:0] m;
        logic [63:0] maxpos;
        logic [63:0] minneg;
        logic [63:0] ta [6];
        logic [63:0] tb [6];
        logic        tc [6];
        logic        ts [6];
        m      = (W[i] == 64) ? {64{1'b1}} : ((64'd1 << W[i]) - 64'd1);
        maxpos = m >> 1;
        minneg = 64'd1 << (W[i] - 1);
        ta = '{64'd1, m,     m, maxpos - 64'd1, 64'd5, minneg};
        tb = '{64'd1, 64'd0, m, maxpos - 64'd1, 64'd7, 64'd1};
        tc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            send(i, ta[k], tb[k], tc[k], ts[k]);
            idle(i);
            wait_cycles(ST[i] + 3);
        end
        for (int k = 0; k < 6; k++) begin
            send(i, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(i);
    endtask

    // Hold off the consumer for three cycles and watch the frozen output.
    task automatic stall_window();
        logic [63:0] snap;
        logic [5:0]  fl;
        orr[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            fl = get_fl(0);
            chk("stall_in_ready", 0, {63'd0, fl[5]}, 64'd0);
            chk("stall_out_valid", 0, {63'd0, fl[4]}, 64'd1);
            if (c == 0) snap = get_sum(0);
            else chk("stall_sum_stable", 0, get_sum(0), snap);
            @(posedge clk);
            #1;
        end
        orr[0] = 1'b1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && g < 300) begin
            wait_cycles(1);
            g++;
        end
        if (g >= 300) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", qsize(0) + qsize(1) + qsize(2));
        end
    endtask

    initial begin
        logic [5:0] fl;
        rst_n = 1'b0;
        iv    = 3'b000;
        orr   = 3'b111;
        a_s   = 64'd0;
        b_s   = 64'd0;
        cin_s = 1'b0;
        sub_s = 1'b0;
        wait_cycles(3);
        for (int i = 0; i < 3; i++) begin
            fl = get_fl(i);
            chk("reset_out_valid", i, {63'd0, fl[4]}, 64'd0);
            chk("reset_sum", i, get_sum(i), 64'd0);
            chk("reset_flags", i, {60'd0, fl[3:0]}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            fl = get_fl(i);
            chk("post_reset_in_ready", i, {63'd0, fl[5]}, 64'd1);
        end
        wait_cycles(1);

        // Directed corner cases plus a short random burst for each geometry.
        for (int i = 0; i < 3; i++) begin
            directed(i);
            drain();
        end

        // Ten back-to-back random ops with a 3-cycle consumer stall once full.
        for (int k = 0; k < 10; k++) begin
            if (k == 6) begin
                fork
                    stall_window();
                join_none
            end
            send(0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(0);
        drain();
        wait_cycles(4);

        // Asynchronous reset with three operations in flight.
        for (int k = 0; k < 3; k++) begin
            send(0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0);
        end
        idle(0);
        #2;
        rst_n = 1'b0;
        #1;
        fl = get_fl(0);
        chk("async_rst_out_valid", 0, {63'd0, fl[4]}, 64'd0);
        chk("async_rst_sum", 0, get_sum(0), 64'd0);
        chk("async_rst_flags", 0, {60'd0, fl[3:0]}, 64'd0);
        q0.delete();
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fl = get_fl(0);
        chk("rst_release_in_ready", 0, {63'd0, fl[5]}, 64'd1);
        wait_cycles(12);
        send(0, 64'h0000_0000_1234_5678, 64'h0000_0000_0FED_CBA9, 1'b1, 1'b0);
        idle(0);
        drain();
        wait_cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's fixed 16-bit combinational CLA.
- The word is split into STAGES slices. Each slice is a 4-bit-block lookahead adder, and a register sits between slices.
- The block accepts one operation per cycle under a valid/ready handshake and stalls on backpressure.
- It serves as the datapath adder for wide multi-cycle ALU paths.

Parameters:
- WIDTH, 32: operand and sum width. Must be a multiple of 4*STAGES.
- STAGES, 4: number of pipeline stages, which is also the latency. SLICE = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in. Ignored when sub=1.
- sub  input  1  0: a+b+cin. 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out. When sub=1 this is NOT borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- grp_p  output  1  whole-word group propagate: AND of (a^b_eff) over all bits.
- grp_g  output  1  whole-word group generate: lookahead G of the full word.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits, out_valid, sum, cout, ovf, grp_p and grp_g go to 0.
  - Skew and deskew data registers go to 0.
  - After release, in_ready=1.
  - Reset asserted mid-stream discards all in-flight operations. No partial result is ever presented.
- Effective operands: b_eff = sub ? ~b : b, c0 = sub ? 1 : cin. Both are captured at acceptance.
- Transfer: occurs on a rising edge with in_valid && in_ready.
- Advance rule (global stall): adv = !out_valid || out_ready, and in_ready = adv.
  - All stages shift together only when adv=1.
  - When adv=0 every register holds its value, and outputs are stable until accepted.
- Stage k (0..STAGES-1):
  - Adds bits [k*SLICE +: SLICE] using 4-bit CLA groups with second-level lookahead across the slice.
  - Carry-in is the carry registered by stage k-1; stage 0 uses c0.
  - Registers its slice sum, its carry out and its valid bit.
  - Accumulates the running group P/G (P_acc &= P_slice; G_acc = G_slice | P_slice & G_acc).
  - For the MSB slice, captures the carry into the MSB for ovf.
- Skew/deskew:
  - Operand slices not yet consumed travel in skew registers.
  - Completed lower sum slices travel in deskew registers.
  - All WIDTH sum bits are therefore presented in the same cycle.
- Latency:
  - An operation accepted at edge t presents out_valid=1 after edge t+STAGES, given no stalls.
  - Each stall cycle adds one cycle.
  - STAGES=1 gives a single registered result, latency 1.
- Throughput: one result per cycle when out_ready stays 1.
- Bubbles: a cycle with in_valid=0 inserts an invalid slot that flows through. Bubbles are not collapsed.
- Ordering and count: results exit in acceptance order. None are dropped or duplicated across stalls.
- Simultaneous events:
  - out_ready=1 with a new acceptance in the same cycle is legal, and the pipeline stays full.
  - Input is sampled only on an accepting edge. a, b, cin and sub may change freely otherwise.
- Wrap-around: sum is modulo 2^WIDTH. The carry is reported only in cout.
- Output hold: sum, cout, ovf, grp_p and grp_g hold their last values while out_valid=0, except after reset, when they are 0.

Test Plan:
(WIDTH=32, STAGES=4 unless noted)
1. Reset, then a=0x00000001, b=0x00000001, cin=1, sub=0 for one cycle, out_ready=1.
   -> sum=0x00000003, cout=0, ovf=0, grp_p=0, grp_g=0.
   -> out_valid high exactly 4 cycles after acceptance, for 1 cycle.
2. Full-length carry: a=0xFFFFFFFF, b=0, cin=1.
   -> sum=0, cout=1, ovf=0, grp_p=1, grp_g=0.
   Then a=b=0xFFFFFFFF, cin=1.
   -> sum=0xFFFFFFFF, cout=1, ovf=0, grp_p=0, grp_g=1.
   Then a=b=0x7FFFFFFE, cin=1.
   -> sum=0xFFFFFFFD, ovf=1, cout=0.
3. Subtract: a=5, b=7, sub=1, cin=1 (ignored).
   -> sum=0xFFFFFFFE, cout=0, ovf=0.
   Then a=0x80000000, b=1, sub=1.
   -> sum=0x7FFFFFFF, cout=1, ovf=1.
4. Stream 10 random operations back-to-back, with out_ready=0 for 3 cycles once the pipeline is full.
   -> in_ready=0 during the stall, outputs stable while stalled.
   -> all 10 results match the reference model in order, with no duplicates.
5. Assert rst_n=0 asynchronously (between edges) while 3 operations are in flight.
   -> out_valid and all outputs go to 0 immediately.
   -> after release, in_ready=1 and none of the old results ever appear.
6. Re-run scenarios 1-3 with WIDTH=16, STAGES=1 and with WIDTH=64, STAGES=8.
   -> results identical modulo width.
   -> latency 1 and 8 respectively.
